// File: rtl/prng_ctrl_if.sv
// Bundle of requester/generator signals shared by prng_ctrl and its environment.
// Optional seed-load inputs exist only when PRNG_CTRL_SEED_EN is defined.
// master = the controller side, slave = requesters plus generator.
interface prng_ctrl_if #(
    parameter int WORD_W = 8
);
    logic [1:0]        REQ;
    logic [1:0]        GNT;
    logic              RVALID;
    logic [WORD_W-1:0] RDATA;
    logic [1:0]        RACK;
    logic [1:0]        MODE;
    logic [3:0]        SEED;
    logic              SOUT;
`ifdef PRNG_CTRL_SEED_EN
    logic [3:0]        SEED_IN;
    logic              SEED_LD;

    modport master (
        input  REQ, RACK, SOUT, SEED_IN, SEED_LD,
        output GNT, RVALID, RDATA, MODE, SEED
    );
    modport slave (
        output REQ, RACK, SOUT, SEED_IN, SEED_LD,
        input  GNT, RVALID, RDATA, MODE, SEED
    );
`else
    modport master (
        input  REQ, RACK, SOUT,
        output GNT, RVALID, RDATA, MODE, SEED
    );
    modport slave (
        output REQ, RACK, SOUT,
        input  GNT, RVALID, RDATA, MODE, SEED
    );
`endif
endinterface

// File: rtl/prng_ctrl.sv
// prng_ctrl: two-requester round-robin front end for a serial LFSR generator.
// A grant steps the generator WORD_W times, assembles the serial bits MSB
// first into a word, presents it with RVALID and waits for the owner's RACK.
// Optional seed loading is compiled in with macro PRNG_CTRL_SEED_EN.
module prng_ctrl #(
    parameter int WORD_W = 8
) (
    input  logic       CLK,
    input  logic       RSTn,
    prng_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(WORD_W + 1);

`ifdef PRNG_CTRL_SEED_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEED = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd2, S_DONE = 2'd3} state_t;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_gnt;
    logic                r_last;        // index of the requester granted last
    logic [CNT_W-1:0]    r_cnt;
    logic [WORD_W-2:0]   r_shift;       // MSB of the word never needs storing
    logic [WORD_W-1:0]   r_rdata;
    logic                r_rvalid;

    logic                w_start;
    logic                w_win;
    logic                w_ack;
    logic                w_last_bit;
    logic [WORD_W-1:0]   w_shift_next;
    logic                w_seed_pend;

    // Simultaneous requests go to the one not served last; otherwise the lone requester wins.
    assign w_win        = (bus.REQ == 2'b11) ? ~r_last : bus.REQ[1];
    // Only the granted requester's acknowledge counts; r_gnt is zero outside a transaction.
    assign w_ack        = |(bus.RACK & r_gnt);
    assign w_shift_next = {r_shift, bus.SOUT};
    assign w_last_bit   = (r_state == S_RUN) && (r_cnt == CNT_W'(WORD_W - 1));

`ifdef PRNG_CTRL_SEED_EN
    logic        r_seed_pend;
    logic [3:0]  r_seed_val;

    // A pulse arriving in the same cycle as the IDLE decision counts as pending.
    assign w_seed_pend = r_seed_pend | bus.SEED_LD;

    // Capture seed pulses in any state; the IDLE->SEED transition consumes them.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_seed_pend <= 1'b0;
            r_seed_val  <= 4'h0;
        end else begin
            if (bus.SEED_LD) begin
                r_seed_val <= bus.SEED_IN;
            end
            if (r_state == S_IDLE && w_seed_pend) begin
                r_seed_pend <= 1'b0;
            end else if (bus.SEED_LD) begin
                r_seed_pend <= 1'b1;
            end
        end
    end

    assign bus.SEED = (r_state == S_SEED) ? r_seed_val : 4'h0;
    assign bus.MODE = (r_state == S_RUN)  ? 2'b11 :
                      (r_state == S_SEED) ? 2'b01 : 2'b00;
`else
    assign w_seed_pend = 1'b0;
    assign bus.SEED    = 4'h0;
    assign bus.MODE    = (r_state == S_RUN) ? 2'b11 : 2'b00;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a pending seed load beats a request seen in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_seed_pend) begin
`ifdef PRNG_CTRL_SEED_EN
                    w_state_next = S_SEED;
`endif
                end else if (|bus.REQ) begin
                    w_state_next = S_RUN;
                    w_start      = 1'b1;
                end
            end
`ifdef PRNG_CTRL_SEED_EN
            S_SEED: w_state_next = S_IDLE;
`endif
            S_RUN: begin
                if (w_last_bit) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Grant, bit capture and result presentation.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_gnt    <= 2'b00;
            r_last   <= 1'b1;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_start) begin
                r_gnt  <= w_win ? 2'b10 : 2'b01;
                r_last <= w_win;
                r_cnt  <= '0;
            end
            if (r_state == S_RUN) begin
                r_shift <= w_shift_next[WORD_W-2:0];
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last_bit) begin
                    r_rdata  <= w_shift_next;
                    r_rvalid <= 1'b1;
                end
            end
            if (r_state == S_DONE && w_ack) begin
                r_rvalid <= 1'b0;
                r_gnt    <= 2'b00;
            end
        end
    end

    assign bus.GNT    = r_gnt;
    assign bus.RVALID = r_rvalid;
    assign bus.RDATA  = r_rdata;
endmodule
